mmcm_ps_seq: RTL and testbench



---
 rtl/mmcm_ps_seq_pkg.sv | 17 +
 rtl/mmcm_ps_lock_sync.sv | 24 ++
 rtl/mmcm_ps_seq.sv | 125 ++++++++++++
 tb/tb_mmcm_ps_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_ps_seq_pkg.sv
// Shared types and defaults for the MMCM fine phase-shift sequencer.
package mmcm_ps_seq_pkg;

  localparam int PS_BITS_DEF = 11;
  localparam int PS_MIN_DEF  = -448;
  localparam int PS_MAX_DEF  = 447;
  localparam int TMO_CYC_DEF = 1023;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    STEP      = 3'd2,
    WAIT_DONE = 3'd3,
    ERR       = 3'd4
  } ps_state_e;

endpackage

// File: rtl/mmcm_ps_lock_sync.sv
// Two-flop synchroniser bringing MMCM LOCKED into the clk domain.
module mmcm_ps_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/mmcm_ps_seq.sv
// Steps the MMCM fine phase shift one PSEN at a time toward a run-time
// target and re-applies that target after every relock.
import mmcm_ps_seq_pkg::*;

module mmcm_ps_seq #(
  parameter int PS_BITS = PS_BITS_DEF,
  parameter int PS_MIN  = PS_MIN_DEF,
  parameter int PS_MAX  = PS_MAX_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked,
  input  logic [PS_BITS-1:0] target,
  input  logic               target_we,
  output logic               ps_en,
  output logic               ps_incdec,
  input  logic               ps_done,
  output logic [PS_BITS-1:0] phase,
  output logic               busy,
  output logic               settled,
  output logic               err
);

  localparam int TMR_W = $clog2(TMO_CYC + 1);

  ps_state_e state_q, state_d;
  logic signed [PS_BITS-1:0] phase_q, phase_d;
  logic signed [PS_BITS-1:0] tgt_q, tgt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic inc_q, inc_d;
  logic err_q, err_d;
  logic lock_s;
  logic up;

  mmcm_ps_lock_sync u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  assign up = tgt_q > phase_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tgt_d   = tgt_q;
    tmr_d   = tmr_q;
    inc_d   = inc_q;
    err_d   = err_q;

    if (target_we) begin
      if ($signed(target) < PS_MIN)
        tgt_d = PS_BITS'(PS_MIN);
      else if ($signed(target) > PS_MAX)
        tgt_d = PS_BITS'(PS_MAX);
      else
        tgt_d = $signed(target);
    end

    unique case (state_q)
      WAIT_LOCK: begin
        phase_d = '0;
        if (lock_s) state_d = IDLE;
      end
      IDLE: begin
        if (phase_q != tgt_q) state_d = STEP;
      end
      STEP: begin
        inc_d   = up;
        tmr_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmr_d = tmr_q + 1'b1;
        if (ps_done) begin
          phase_d = inc_q ? phase_q + PS_BITS'(1)
                          : phase_q - PS_BITS'(1);
          state_d = IDLE;
        end else if (tmr_d == TMR_W'(TMO_CYC)) begin
          // err lands TMO_CYC+1 clk after the PSEN pulse
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: ;
      default: state_d = WAIT_LOCK;
    endcase

    // MMCM reset wipes the fine shift; keep target, drop everything else
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      phase_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      phase_q <= '0;
      tgt_q   <= '0;
      tmr_q   <= '0;
      inc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
    end
  end

  assign ps_en     = state_q == STEP;
  assign ps_incdec = (state_q == STEP) ? up : inc_q;
  assign phase     = phase_q;
  assign err       = err_q;
  assign busy      = (state_q == STEP) || (state_q == WAIT_DONE) ||
                     ((state_q == IDLE) && (phase_q != tgt_q));
  assign settled   = (state_q == IDLE) && (phase_q == tgt_q) && lock_s;

endmodule

// File: tb/tb_mmcm_ps_seq.sv
// Directed bench for mmcm_ps_seq with a PSDONE-after-12-clk MMCM model.
module tb_mmcm_ps_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic [10:0] target;
  logic        target_we;
  logic        ps_en;
  logic        ps_incdec;
  logic        ps_done;
  logic [10:0] phase;
  logic        busy;
  logic        settled;
  logic        err;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int prev   = -1;
  int last_pulse = 0;
  int pulses = 0;
  int cd     = 0;
  bit drop   = 0;
  bit exp_q[$];

  mmcm_ps_seq dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .target    (target),
    .target_we (target_we),
    .ps_en     (ps_en),
    .ps_incdec (ps_incdec),
    .ps_done   (ps_done),
    .phase     (phase),
    .busy      (busy),
    .settled   (settled),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic signed [31:0] obs,
                       logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // MMCM model: PSDONE high for one cycle, 12 clk after PSEN
  initial begin
    ps_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ps_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) ps_done = 1'b1;
      end
      if (ps_en && !drop) cd = 12;
    end
  end

  // Scoreboard: every PSEN pops one expected direction
  always @(negedge clk) begin
    if (!rst && ps_en) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_psen", 1, 0);
      end else begin
        check("incdec", {31'd0, ps_incdec}, {31'd0, exp_q.pop_front()});
      end
      if (prev >= 0) check("spacing_ge14", {31'd0, (cyc - prev) >= 14}, 1);
      prev = cyc;
      last_pulse = cyc;
    end
  end

  task automatic push(int n, bit dir);
    for (int i = 0; i < n; i++) exp_q.push_back(dir);
    prev = -1;
  endtask

  task automatic write_target(int v);
    @(posedge clk);
    #1;
    target = 11'(v);
    target_we = 1'b1;
    @(posedge clk);
    #1;
    target_we = 1'b0;
  endtask

  task automatic wait_settled(string tag, int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (!(settled && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n < budget}, 1);
  endtask

  task automatic wait_pulses(string tag, int cnt, int budget);
    int n = 0;
    while (pulses < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n < budget}, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    int err_cyc;
    rst = 1'b1;
    locked = 1'b0;
    target = '0;
    target_we = 1'b0;
    #22;
    check("rst_ps_en", {31'd0, ps_en}, 0);
    check("rst_incdec", {31'd0, ps_incdec}, 0);
    check("rst_phase", $signed(phase), 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_settled", {31'd0, settled}, 0);
    check("rst_err", {31'd0, err}, 0);
    #1 locked = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("lock_settled", {31'd0, settled}, 1);

    // 1: 0 -> 5
    push(5, 1'b1);
    write_target(5);
    wait_settled("t1_settle", 300);
    check("t1_phase", $signed(phase), 5);
    check("t1_settled", {31'd0, settled}, 1);

    // 2: 5 -> -3, then clamp -1000 -> -448
    push(8, 1'b0);
    write_target(-3);
    wait_settled("t2_settle", 300);
    check("t2_phase", $signed(phase), -3);
    push(445, 1'b0);
    write_target(-1000);
    wait_settled("t2_clamp_settle", 7000);
    check("t2_clamp_phase", $signed(phase), -448);
    check("t2_busy", {31'd0, busy}, 0);
    do_reset();

    // 3: retarget while step 3 in flight
    push(3, 1'b1);
    push(3, 1'b0);
    n = pulses;
    write_target(20);
    wait_pulses("t3_third", n + 3, 200);
    repeat (3) @(negedge clk);
    check("t3_busy_mid", {31'd0, busy}, 1);
    write_target(0);
    wait_settled("t3_settle", 300);
    check("t3_phase", $signed(phase), 0);

    // 4: PSDONE never arrives
    drop = 1'b1;
    push(1, 1'b1);
    n = pulses;
    write_target(1);
    wait_pulses("t4_pulse", n + 1, 50);
    n = 0;
    while (!err && n < 1100) begin
      @(negedge clk);
      n++;
    end
    err_cyc = cyc;
    check("t4_err", {31'd0, err}, 1);
    check("t4_err_delay", err_cyc - last_pulse, 1024);
    write_target(7);
    repeat (40) @(negedge clk);
    check("t4_err_sticky", {31'd0, err}, 1);
    check("t4_phase", $signed(phase), 0);
    check("t4_settled", {31'd0, settled}, 0);
    drop = 1'b0;
    do_reset();

    // 5: lock loss re-applies target
    push(10, 1'b1);
    write_target(10);
    wait_settled("t5_settle", 400);
    check("t5_phase", $signed(phase), 10);
    @(posedge clk);
    #3 locked = 1'b0;
    repeat (3) @(posedge clk);
    #3 locked = 1'b1;
    push(10, 1'b1);
    @(negedge clk);
    check("t5_phase_lost", $signed(phase), 0);
    check("t5_settled_lost", {31'd0, settled}, 0);
    wait_settled("t5_relock", 400);
    check("t5_phase_relock", $signed(phase), 10);

    // 6: async reset mid-WAIT_DONE, late PSDONE ignored
    push(1, 1'b1);
    n = pulses;
    write_target(13);
    wait_pulses("t6_pulse", n + 1, 50);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_ps_en", {31'd0, ps_en}, 0);
    check("t6_incdec", {31'd0, ps_incdec}, 0);
    check("t6_phase", $signed(phase), 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_err", {31'd0, err}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_phase_late", $signed(phase), 0);
    check("t6_settled", {31'd0, settled}, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
